// File: rtl/reg_bus_cfg_pkg.sv
// hyper_cfg_pkg: configuration struct, register offsets and reset values
// for the HyperBus controller register file.
package hyper_cfg_pkg;

   typedef struct packed {
      logic [3:0]  t_latency_access;
      logic        en_latency_additional;
      logic [15:0] t_burst_max;
      logic [3:0]  t_read_write_recovery;
      logic [3:0]  t_rx_clk_delay;
      logic [3:0]  t_tx_clk_delay;
      logic [4:0]  address_mask_msb;
      logic        address_space;
      logic        phys_in_use;
      logic        which_phy;
   } hyper_cfg_t;

   localparam int unsigned REG_T_LATENCY_ACCESS      = 'h00;
   localparam int unsigned REG_EN_LATENCY_ADDITIONAL = 'h04;
   localparam int unsigned REG_T_BURST_MAX           = 'h08;
   localparam int unsigned REG_T_READ_WRITE_RECOVERY = 'h0C;
   localparam int unsigned REG_T_RX_CLK_DELAY        = 'h10;
   localparam int unsigned REG_T_TX_CLK_DELAY        = 'h14;
   localparam int unsigned REG_ADDRESS_MASK_MSB      = 'h18;
   localparam int unsigned REG_ADDRESS_SPACE         = 'h1C;
   localparam int unsigned REG_PHYS_IN_USE           = 'h20;
   localparam int unsigned REG_WHICH_PHY             = 'h24;

   localparam logic [3:0]  RST_T_LATENCY_ACCESS      = 4'd6;
   localparam logic        RST_EN_LATENCY_ADDITIONAL = 1'b1;
   localparam logic [15:0] RST_T_BURST_MAX           = 16'd350;
   localparam logic [3:0]  RST_T_READ_WRITE_RECOVERY = 4'd6;
   localparam logic [3:0]  RST_T_RX_CLK_DELAY        = 4'd8;
   localparam logic [3:0]  RST_T_TX_CLK_DELAY        = 4'd8;
   localparam logic [4:0]  RST_ADDRESS_MASK_MSB      = 5'd25;
   localparam logic        RST_ADDRESS_SPACE         = 1'b0;

   // PHY selection defaults to interleaved on dual-PHY builds, PHY 1 on single-PHY builds
   function automatic hyper_cfg_t cfg_reset(input int unsigned num_phys);
      hyper_cfg_t c;
      c.t_latency_access      = RST_T_LATENCY_ACCESS;
      c.en_latency_additional = RST_EN_LATENCY_ADDITIONAL;
      c.t_burst_max           = RST_T_BURST_MAX;
      c.t_read_write_recovery = RST_T_READ_WRITE_RECOVERY;
      c.t_rx_clk_delay        = RST_T_RX_CLK_DELAY;
      c.t_tx_clk_delay        = RST_T_TX_CLK_DELAY;
      c.address_mask_msb      = RST_ADDRESS_MASK_MSB;
      c.address_space         = RST_ADDRESS_SPACE;
      c.phys_in_use           = (num_phys == 2);
      c.which_phy             = (num_phys != 2);
      return c;
   endfunction

   function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [3:0] wstrb);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/reg_bus_cfg.sv
// reg_bus_cfg: REG_BUS-accessible HyperBus PHY timing/selection register file.
// Define HYPER_CFG_ERR_EN to flag accesses to unmapped offsets on reg_error_o.
module reg_bus_cfg
   import hyper_cfg_pkg::*;
#(
   parameter int unsigned NumPhys = 2,
   parameter int unsigned RegAw   = 8,
   parameter int unsigned RegDw   = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [RegAw-1:0] reg_addr_i,
   input  logic             reg_write_i,
   input  logic [RegDw-1:0] reg_wdata_i,
   input  logic [3:0]       reg_wstrb_i,
   input  logic             reg_valid_i,
   output logic [RegDw-1:0] reg_rdata_o,
   output logic             reg_error_o,
   output logic             reg_ready_o,
   input  logic             trans_active_i,
   output hyper_cfg_t       cfg_o
);

   localparam hyper_cfg_t CfgRst = cfg_reset(NumPhys);

   hyper_cfg_t       r_cfg;
   logic [RegAw-1:0] w_addr;
   logic [31:0]      w_wdata;
   logic [31:0]      w_rd;
   logic             w_hs;
   logic             w_wr;
   logic             w_mapped;

   assign w_addr      = reg_addr_i & ~RegAw'(3);
   assign w_wdata     = 32'(reg_wdata_i);
   assign w_hs        = reg_valid_i & ~trans_active_i;
   assign w_wr        = w_hs & reg_write_i & w_mapped;
   assign reg_ready_o = w_hs;
   assign reg_rdata_o = w_hs ? RegDw'(w_rd) : '0;
   assign cfg_o       = r_cfg;

`ifdef HYPER_CFG_ERR_EN
   assign reg_error_o = w_hs & ~w_mapped;
`else
   assign reg_error_o = 1'b0;
`endif

   always_comb begin
      w_rd     = '0;
      w_mapped = 1'b1;
      case (w_addr)
         RegAw'(REG_T_LATENCY_ACCESS):      w_rd = 32'(r_cfg.t_latency_access);
         RegAw'(REG_EN_LATENCY_ADDITIONAL): w_rd = 32'(r_cfg.en_latency_additional);
         RegAw'(REG_T_BURST_MAX):           w_rd = 32'(r_cfg.t_burst_max);
         RegAw'(REG_T_READ_WRITE_RECOVERY): w_rd = 32'(r_cfg.t_read_write_recovery);
         RegAw'(REG_T_RX_CLK_DELAY):        w_rd = 32'(r_cfg.t_rx_clk_delay);
         RegAw'(REG_T_TX_CLK_DELAY):        w_rd = 32'(r_cfg.t_tx_clk_delay);
         RegAw'(REG_ADDRESS_MASK_MSB):      w_rd = 32'(r_cfg.address_mask_msb);
         RegAw'(REG_ADDRESS_SPACE):         w_rd = 32'(r_cfg.address_space);
         RegAw'(REG_PHYS_IN_USE):           w_rd = 32'(r_cfg.phys_in_use);
         RegAw'(REG_WHICH_PHY):             w_rd = 32'(r_cfg.which_phy);
         default:                           w_mapped = 1'b0;
      endcase
   end

   // Each field merges strobed bytes over its zero-extended value, then truncates to its width
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_cfg <= CfgRst;
      else if (w_wr) begin
         case (w_addr)
            RegAw'(REG_T_LATENCY_ACCESS):
               r_cfg.t_latency_access <= 4'(strb_merge(32'(r_cfg.t_latency_access), w_wdata, reg_wstrb_i));
            RegAw'(REG_EN_LATENCY_ADDITIONAL):
               r_cfg.en_latency_additional <= 1'(strb_merge(32'(r_cfg.en_latency_additional), w_wdata, reg_wstrb_i));
            RegAw'(REG_T_BURST_MAX):
               r_cfg.t_burst_max <= 16'(strb_merge(32'(r_cfg.t_burst_max), w_wdata, reg_wstrb_i));
            RegAw'(REG_T_READ_WRITE_RECOVERY):
               r_cfg.t_read_write_recovery <= 4'(strb_merge(32'(r_cfg.t_read_write_recovery), w_wdata, reg_wstrb_i));
            RegAw'(REG_T_RX_CLK_DELAY):
               r_cfg.t_rx_clk_delay <= 4'(strb_merge(32'(r_cfg.t_rx_clk_delay), w_wdata, reg_wstrb_i));
            RegAw'(REG_T_TX_CLK_DELAY):
               r_cfg.t_tx_clk_delay <= 4'(strb_merge(32'(r_cfg.t_tx_clk_delay), w_wdata, reg_wstrb_i));
            RegAw'(REG_ADDRESS_MASK_MSB):
               r_cfg.address_mask_msb <= 5'(strb_merge(32'(r_cfg.address_mask_msb), w_wdata, reg_wstrb_i));
            RegAw'(REG_ADDRESS_SPACE):
               r_cfg.address_space <= 1'(strb_merge(32'(r_cfg.address_space), w_wdata, reg_wstrb_i));
            RegAw'(REG_PHYS_IN_USE):
               if (NumPhys == 2) r_cfg.phys_in_use <= 1'(strb_merge(32'(r_cfg.phys_in_use), w_wdata, reg_wstrb_i));
            RegAw'(REG_WHICH_PHY):
               if (NumPhys == 2) r_cfg.which_phy <= 1'(strb_merge(32'(r_cfg.which_phy), w_wdata, reg_wstrb_i));
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bus_cfg.sv
// tb_reg_bus_cfg: scoreboard bench driving a dual-PHY and a single-PHY instance on one shared bus.
module tb_reg_bus_cfg;
   import hyper_cfg_pkg::*;

`ifdef HYPER_CFG_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  addr = '0;
   logic        wr = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  strb = '0;
   logic        valid = 1'b0;
   logic        trans = 1'b0;
   logic [31:0] rdata, rdata1;
   logic        err, err1, ready, ready1;
   hyper_cfg_t  cfg, cfg1;
   hyper_cfg_t  m, m1, rst2, rst1;
   logic [32:0] exp_q[$];
   logic [32:0] exp1_q[$];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   reg_bus_cfg #(.NumPhys(2), .RegAw(8), .RegDw(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .reg_addr_i(addr), .reg_write_i(wr), .reg_wdata_i(wdata),
      .reg_wstrb_i(strb), .reg_valid_i(valid), .reg_rdata_o(rdata), .reg_error_o(err),
      .reg_ready_o(ready), .trans_active_i(trans), .cfg_o(cfg));

   reg_bus_cfg #(.NumPhys(1), .RegAw(8), .RegDw(32)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .reg_addr_i(addr), .reg_write_i(wr), .reg_wdata_i(wdata),
      .reg_wstrb_i(strb), .reg_valid_i(valid), .reg_rdata_o(rdata1), .reg_error_o(err1),
      .reg_ready_o(ready1), .trans_active_i(trans), .cfg_o(cfg1));

   // Drives one request, waits (bounded) for the handshake and returns what both instances showed.
   task automatic bus(input logic [7:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic er, output logic [31:0] rd1,
                      output logic er1, output bit to);
      addr = a; wr = w; wdata = d; strb = s; valid = 1'b1; to = 1'b1;
      rd = 'x; er = 'x; rd1 = 'x; er1 = 'x;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ready) begin
            rd = rdata; er = err; rd1 = rdata1; er1 = err1; to = 1'b0;
            break;
         end
      end
      @(posedge clk); #1;
      valid = 1'b0; wr = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] rv [10] = '{32'd6, 32'd1, 32'd350, 32'd6, 32'd8, 32'd8, 32'd25, 32'd0, 32'd1, 32'd0};
      logic [31:0] rd, rd1;
      logic er, er1;
      logic [32:0] e;
      bit to;
      rst_n = 1'b0; valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", ready); end
      n_chk++;
      if (cfg !== rst2) begin n_fail++; $display("FAIL reset_cfg2 got=%h want=%h", cfg, rst2); end
      n_chk++;
      if (cfg1 !== rst1) begin n_fail++; $display("FAIL reset_cfg1 got=%h want=%h", cfg1, rst1); end
      valid = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back({1'b0, rv[i]});
         exp1_q.push_back({1'b0, (i == 8) ? 32'd0 : (i == 9) ? 32'd1 : rv[i]});
         bus(8'(i * 4), 1'b0, '0, '0, rd, er, rd1, er1, to);
         n_chk++;
         if (to) begin n_fail++; $display("FAIL reset_read_timeout addr=%0h", i * 4); end
         e = exp_q.pop_front();
         n_chk++;
         if ({er, rd} !== e) begin n_fail++; $display("FAIL reset_read addr=%0h got=%b/%h want=%b/%h", i * 4, er, rd, e[32], e[31:0]); end
         e = exp1_q.pop_front();
         n_chk++;
         if ({er1, rd1} !== e) begin n_fail++; $display("FAIL reset_read1 addr=%0h got=%b/%h want=%b/%h", i * 4, er1, rd1, e[32], e[31:0]); end
      end
   endtask

   task automatic test_phy_sel;
      logic [31:0] rd, rd1;
      logic er, er1;
      logic [32:0] e;
      bit to;
      bus(8'h20, 1'b1, 32'h0, 4'hF, rd, er, rd1, er1, to);
      m.phys_in_use = 1'b0;
      n_chk++;
      if (to || cfg.phys_in_use !== 1'b0) begin n_fail++; $display("FAIL phys_in_use_wr got=%b want=0 to=%b", cfg.phys_in_use, to); end
      bus(8'h24, 1'b1, 32'h0, 4'hF, rd, er, rd1, er1, to);
      n_chk++;
      if (to || cfg.which_phy !== 1'b0) begin n_fail++; $display("FAIL which_phy_wr0 got=%b want=0", cfg.which_phy); end
      bus(8'h24, 1'b1, 32'h1, 4'hF, rd, er, rd1, er1, to);
      m.which_phy = 1'b1;
      n_chk++;
      if (to || cfg.which_phy !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL which_phy_wr1 got=%b/err=%b want=1/0", cfg.which_phy, er); end
      exp_q.push_back({1'b0, 32'd1});
      bus(8'h24, 1'b0, '0, '0, rd, er, rd1, er1, to);
      e = exp_q.pop_front();
      n_chk++;
      if (to || {er, rd} !== e) begin n_fail++; $display("FAIL which_phy_rd got=%b/%h want=%b/%h", er, rd, e[32], e[31:0]); end
   endtask

   task automatic test_strobe;
      logic [31:0] rd, rd1;
      logic er, er1;
      logic [32:0] e;
      bit to;
      bus(8'h08, 1'b1, 32'h0, 4'hF, rd, er, rd1, er1, to);
      bus(8'h08, 1'b1, 32'hAABB_CCDD, 4'h1, rd, er, rd1, er1, to);
      exp_q.push_back({1'b0, 32'h0000_00DD});
      bus(8'h08, 1'b0, '0, '0, rd, er, rd1, er1, to);
      e = exp_q.pop_front();
      n_chk++;
      if (to || {er, rd} !== e) begin n_fail++; $display("FAIL strb_byte0 got=%h want=%h", rd, e[31:0]); end
      bus(8'h08, 1'b1, 32'hFFFF_12FF, 4'h2, rd, er, rd1, er1, to);
      exp_q.push_back({1'b0, 32'h0000_12DD});
      bus(8'h0A, 1'b0, '0, '0, rd, er, rd1, er1, to);
      e = exp_q.pop_front();
      n_chk++;
      if (to || {er, rd} !== e) begin n_fail++; $display("FAIL strb_byte1 got=%h want=%h", rd, e[31:0]); end
      bus(8'h10, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, rd1, er1, to);
      exp_q.push_back({1'b0, 32'h0000_000F});
      exp1_q.push_back({1'b0, 32'h0000_000F});
      bus(8'h13, 1'b0, '0, '0, rd, er, rd1, er1, to);
      e = exp_q.pop_front();
      n_chk++;
      if (to || {er, rd} !== e) begin n_fail++; $display("FAIL field_trunc got=%h want=%h", rd, e[31:0]); end
      e = exp1_q.pop_front();
      n_chk++;
      if (to || {er1, rd1} !== e) begin n_fail++; $display("FAIL field_trunc1 got=%h want=%h", rd1, e[31:0]); end
      m.t_burst_max = 16'h12DD; m1.t_burst_max = 16'h12DD;
      m.t_rx_clk_delay = 4'hF;  m1.t_rx_clk_delay = 4'hF;
      n_chk++;
      if (cfg !== m) begin n_fail++; $display("FAIL strb_cfg got=%h want=%h", cfg, m); end
   endtask

   task automatic test_stall;
      logic [31:0] rd, rd1;
      logic er, er1;
      bit to;
      bus(8'h24, 1'b1, 32'h0, 4'hF, rd, er, rd1, er1, to);
      n_chk++;
      if (to || cfg.which_phy !== 1'b0) begin n_fail++; $display("FAIL stall_setup got=%b want=0", cfg.which_phy); end
      trans = 1'b1; addr = 8'h24; wr = 1'b1; wdata = 32'h1; strb = 4'hF; valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++;
         if (ready !== 1'b0 || cfg.which_phy !== 1'b0 || err !== 1'b0 || rdata !== '0)
            begin n_fail++; $display("FAIL stall cyc=%0d ready=%b which_phy=%b want 0/0", i, ready, cfg.which_phy); end
      end
      @(posedge clk); #1;
      trans = 1'b0;
      @(negedge clk);
      n_chk++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL stall_release ready=%b want=1", ready); end
      @(posedge clk); #1;
      valid = 1'b0; wr = 1'b0;
      m.which_phy = 1'b1;
      n_chk++;
      if (cfg.which_phy !== 1'b1) begin n_fail++; $display("FAIL stall_land got=%b want=1", cfg.which_phy); end
   endtask

   task automatic test_unmapped;
      logic [31:0] rd, rd1;
      logic er, er1;
      logic [32:0] e;
      bit to;
      exp_q.push_back({ERR_EN, 32'h0});
      bus(8'h40, 1'b0, '0, '0, rd, er, rd1, er1, to);
      e = exp_q.pop_front();
      n_chk++;
      if (to || {er, rd} !== e) begin n_fail++; $display("FAIL unmapped_rd got=%b/%h want=%b/%h", er, rd, e[32], e[31:0]); end
      bus(8'h40, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, rd1, er1, to);
      n_chk++;
      if (to || er !== ERR_EN || er1 !== ERR_EN) begin n_fail++; $display("FAIL unmapped_wr_err got=%b/%b want=%b", er, er1, ERR_EN); end
      n_chk++;
      if (cfg !== m || cfg1 !== m1) begin n_fail++; $display("FAIL unmapped_state got=%h/%h want=%h/%h", cfg, cfg1, m, m1); end
   endtask

   task automatic test_back_to_back;
      logic [32:0] e;
      addr = 8'h00; wr = 1'b1; wdata = 32'h3; strb = 4'hF; valid = 1'b1;
      @(negedge clk);
      n_chk++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_wr ready=%b want=1", ready); end
      @(posedge clk); #1;
      wr = 1'b0;
      exp_q.push_back({1'b0, 32'h3});
      @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if ({err, rdata} !== e || ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rd got=%b/%h want=%b/%h", err, rdata, e[32], e[31:0]); end
      @(posedge clk); #1;
      valid = 1'b0;
      m.t_latency_access = 4'd3; m1.t_latency_access = 4'd3;
      n_chk++;
      if (cfg !== m) begin n_fail++; $display("FAIL b2b_cfg got=%h want=%h", cfg, m); end
   endtask

   task automatic test_numphys1;
      logic [31:0] rd, rd1;
      logic er, er1;
      logic [32:0] e;
      bit to;
      bus(8'h20, 1'b1, 32'h1, 4'hF, rd, er, rd1, er1, to);
      bus(8'h24, 1'b1, 32'h0, 4'hF, rd, er, rd1, er1, to);
      m.phys_in_use = 1'b1; m.which_phy = 1'b0;
      exp1_q.push_back({1'b0, 32'd0});
      exp1_q.push_back({1'b0, 32'd1});
      exp_q.push_back({1'b0, 32'd1});
      exp_q.push_back({1'b0, 32'd0});
      for (int i = 0; i < 2; i++) begin
         bus(8'(8'h20 + i * 4), 1'b0, '0, '0, rd, er, rd1, er1, to);
         e = exp1_q.pop_front();
         n_chk++;
         if (to || {er1, rd1} !== e) begin n_fail++; $display("FAIL np1_rd%0d got=%h want=%h", i, rd1, e[31:0]); end
         e = exp_q.pop_front();
         n_chk++;
         if (to || {er, rd} !== e) begin n_fail++; $display("FAIL np2_rd%0d got=%h want=%h", i, rd, e[31:0]); end
      end
      n_chk++;
      if (cfg1 !== m1 || cfg !== m) begin n_fail++; $display("FAIL np_cfg got=%h/%h want=%h/%h", cfg1, cfg, m1, m); end
   endtask

   task automatic test_reset_mid;
      addr = 8'h00; wr = 1'b1; wdata = 32'h9; strb = 4'hF; valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (cfg !== rst2 || cfg1 !== rst1) begin n_fail++; $display("FAIL rst_mid got=%h/%h want=%h/%h", cfg, cfg1, rst2, rst1); end
      n_chk++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b want=1", ready); end
      @(posedge clk); #1;
      valid = 1'b0; wr = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (cfg !== rst2) begin n_fail++; $display("FAIL rst_mid_hold got=%h want=%h", cfg, rst2); end
   endtask

   initial begin
      rst2.t_latency_access = 4'd6;      rst2.en_latency_additional = 1'b1;
      rst2.t_burst_max = 16'd350;        rst2.t_read_write_recovery = 4'd6;
      rst2.t_rx_clk_delay = 4'd8;        rst2.t_tx_clk_delay = 4'd8;
      rst2.address_mask_msb = 5'd25;     rst2.address_space = 1'b0;
      rst2.phys_in_use = 1'b1;           rst2.which_phy = 1'b0;
      rst1 = rst2;
      rst1.phys_in_use = 1'b0;           rst1.which_phy = 1'b1;
      m = rst2; m1 = rst1;
      test_reset();
      test_phy_sel();
      test_strobe();
      test_stall();
      test_unmapped();
      test_back_to_back();
      test_numphys1();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
